serial_adder: RTL and testbench

- Bit-serial adder that reuses a single full-adder cell across WIDTH clock cycles.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Shifts the operands LSB-first through the one-bit add cell and returns the WIDTH-bit sum and carry-out through a second valid/ready handshake.
- Sits between an operand producer and a result consumer, as the area-minimal sequential counterpart to the combinational adder.

---
 rtl/serial_adder.sv | 100 ++++++++++
 tb/tb_serial_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first, with valid/ready on both sides.
// Optional subtract mode (extra sub_in port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign bit_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign bit_carry = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                     (b_sh_reg[0] & carry_reg);

  // Subtraction is a + ~b + 1; carry-out then reads as "no borrow".
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub_in ? ~b_in : b_in;
  assign carry_load = sub_in ? 1'b1 : cin;
`else
  assign b_load     = b_in;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            a_sh_reg   <= a_in;
            b_sh_reg   <= b_load;
            carry_reg  <= carry_load;
            sum_sh_reg <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          carry_reg  <= bit_carry;
          sum_sh_reg <= {bit_sum, sum_sh_reg[WIDTH-1:1]};
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Result is gated so nothing but zero is visible outside DONE.
  assign done_valid  = (state_reg == DONE);
  assign start_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign sum_out     = done_valid ? sum_sh_reg : '0;
  assign cout        = done_valid & carry_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8); subtract checks compile in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_in;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in(sub_in),
`endif
    .sum_out(sum_out), .cout(cout),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done_valid; returns edges elapsed since the caller's reference point.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s, input logic [7:0] exp_sum,
                        input logic exp_cout);
    int cyc;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = s;
`else
    if (s) $display("note: subtract request skipped in add-only build");
`endif
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = ~a; b_in = ~b;
    wait_done(cyc);
    check({tag, " latency"}, cyc, WIDTH);
    check({tag, " sum"}, sum_out, exp_sum);
    check({tag, " cout"}, cout, exp_cout);
    check({tag, " busy"}, busy, 1);
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check({tag, " cleared"}, {done_valid, cout, sum_out}, 0);
    $display("op %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d", tag, a, b, c, s, exp_sum, exp_cout);
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb;
    logic rc, rs;
    logic [8:0] full;
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset outputs", {start_ready, done_valid, cout, busy, sum_out}, {4'b1000, 8'h00});

    run_op("basic", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
    run_op("carry1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("carry2", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op("mix", 8'hC3, 8'h5A, 1'b1, 1'b0, 8'h1E, 1'b1);

    // Backpressure plus start_valid noise during RUN and DONE.
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h11; b_in = 8'h22;
    check("noise start_ready in RUN", start_ready, 0);
    wait_done(cyc);
    check("bp latency", cyc, WIDTH);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp sum stable", sum_out, 8'h46);
      check("bp cout stable", cout, 0);
      check("bp start_ready low", start_ready, 0);
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check("back to idle not accepted", {start_ready, busy}, 2'b10);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("accepted from idle", busy, 1);
    wait_done(cyc);
    check("second op latency", cyc, WIDTH);
    check("second op sum", sum_out, 8'h33);
    check("second op cout", cout, 0);
    @(negedge clk); done_ready = 1'b1;
    @(posedge clk); #1; done_ready = 1'b0;
    $display("op backpressure 12+34 then 11+22 checked");

    // Reset mid-operation at RUN bit 3.
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset outputs", {start_ready, done_valid, cout, busy, sum_out}, {4'b1000, 8'h00});
    @(negedge clk); rst_n = 1'b1;
    repeat (WIDTH + 2) begin
      @(posedge clk); #1;
      check("no partial result", done_valid, 0);
    end
    run_op("after reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Short random add sweep against arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = 9'(ra) + 9'(rb) + 9'(rc);
      run_op("rand add", ra, rb, rc, 1'b0, full[7:0], full[8]);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub2", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (rs) begin
        full = {(ra >= rb), 8'(ra - rb)};
      end else begin
        full = 9'(ra) + 9'(rb) + 9'(rc);
      end
      run_op("rand mix", ra, rb, rc, rs, full[7:0], full[8]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
